// File: rtl/or_gate.sv
// ---------------------------------------------------------------------------
// or_gate
//
// Bitwise OR of two operands. The block has a purely combinational result and
// a small registered observation path.
//
// Parameters
//   WIDTH  : operand/result width (1..64)
//   CNT_W  : width of the saturating high-cycle counter (2..32)
//
// Ports
//   clk     in   rising-edge clock for all registered outputs
//   rst     in   synchronous, active-high reset; takes priority over en
//   a, b    in   WIDTH-bit operands
//   en      in   sample enable for every registered output
//   y       out  a | b, combinational, independent of clk/rst/en
//   y_q     out  registered copy of y, loaded on enabled edges
//   y_rise  out  per-bit one-cycle pulse when a bit of y_q goes 0 -> 1
//   any_q   out  registered OR-reduction of y, loaded on enabled edges
//   hi_cnt  out  saturating count of enabled edges where y was non-zero
//   sat     out  high while hi_cnt is all-ones
//
// There is no handshake on this block: inputs are sampled on every rising
// edge, and en qualifies the sample.
// ---------------------------------------------------------------------------
module or_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] y_rise,
  output logic             any_q,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             sat
);

  // The combinational result has no storage in its path, so it remains valid
  // with clk, rst and en tied off and keeps tracking a | b during reset.
  assign y = a | b;

  // Counter is at its ceiling; it holds rather than wrapping back to zero.
  assign sat = (hi_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      y_rise <= '0;
      any_q  <= '0;
      hi_cnt <= '0;
    end else begin
      // The pulse compares the incoming value with the value held in y_q
      // before this edge. Once a pulse fires, y_q is already 1, so the same
      // bit cannot pulse on the next edge. A disabled edge always clears it.
      if (en) begin
        y_rise <= y & ~y_q;
      end else begin
        y_rise <= '0;
      end

      if (en) begin
        y_q   <= y;
        any_q <= |y;
        if ((|y) && !sat) begin
          hi_cnt <= hi_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_or_gate.sv
// ---------------------------------------------------------------------------
// tb_or_gate
//
// Bench for or_gate. It uses two instances:
//   u_w1 : WIDTH=1, CNT_W=2  -- truth table, registered path, hold,
//                               saturation and mid-count reset sequences
//   u_w4 : WIDTH=4, CNT_W=3  -- 4-bit vectors, then randomized traffic that
//                               is compared against a behavioural model
// ---------------------------------------------------------------------------
module tb_or_gate;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1: WIDTH=1, CNT_W=2 ----------------
  logic       rst1, en1;
  logic [0:0] a1, b1, y1, yq1, yr1;
  logic       any1, sat1;
  logic [1:0] cnt1;

  or_gate #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk    (clk),
    .rst    (rst1),
    .a      (a1),
    .b      (b1),
    .en     (en1),
    .y      (y1),
    .y_q    (yq1),
    .y_rise (yr1),
    .any_q  (any1),
    .hi_cnt (cnt1),
    .sat    (sat1)
  );

  // ---------------- DUT 2: WIDTH=4, CNT_W=3 ----------------
  logic       rst4, en4;
  logic [3:0] a4, b4, y4, yq4, yr4;
  logic       any4, sat4;
  logic [2:0] cnt4;

  or_gate #(.WIDTH(4), .CNT_W(3)) u_w4 (
    .clk    (clk),
    .rst    (rst4),
    .a      (a4),
    .b      (b4),
    .en     (en4),
    .y      (y4),
    .y_q    (yq4),
    .y_rise (yr4),
    .any_q  (any4),
    .hi_cnt (cnt4),
    .sat    (sat4)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle one time unit so that sampling
  // happens away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } vec_t;

  vec_t tt1[4];
  vec_t tt4[6];

  // ---------------- behavioural reference for u_w4 ----------------
  // The model follows the documented rules with plain integers: y is the
  // OR of the operands, a bit "rises" if it was 0 in the stored value and 1
  // in the new one, and the counter climbs to 2^3-1 and stays there.
  int m_yq, m_rise, m_any, m_cnt;
  localparam int M_MAX = (1 << 3) - 1;

  task automatic model_edge(input int ra, input int rb, input bit r_rst, input bit r_en);
    int ov;
    int nr;
    ov = ra | rb;
    if (r_rst) begin
      m_yq = 0; m_rise = 0; m_any = 0; m_cnt = 0;
    end else begin
      nr = 0;
      for (int j = 0; j < 4; j++) begin
        if (r_en && ov[j] && !m_yq[j]) nr = nr + (1 << j);
      end
      m_rise = nr;
      if (r_en) begin
        m_yq  = ov;
        m_any = (ov != 0) ? 1 : 0;
        if (ov != 0 && m_cnt < M_MAX) m_cnt = m_cnt + 1;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tt1[0] = '{a: 4'd0, b: 4'd0, y: 4'd0};
    tt1[1] = '{a: 4'd0, b: 4'd1, y: 4'd1};
    tt1[2] = '{a: 4'd1, b: 4'd0, y: 4'd1};
    tt1[3] = '{a: 4'd1, b: 4'd1, y: 4'd1};

    tt4[0] = '{a: 4'b0101, b: 4'b0011, y: 4'b0111};
    tt4[1] = '{a: 4'b0000, b: 4'b0000, y: 4'b0000};
    tt4[2] = '{a: 4'b1000, b: 4'b0000, y: 4'b1000};
    tt4[3] = '{a: 4'b0000, b: 4'b0100, y: 4'b0100};
    tt4[4] = '{a: 4'b1010, b: 4'b0101, y: 4'b1111};
    tt4[5] = '{a: 4'b1100, b: 4'b1100, y: 4'b1100};

    rst1 = 1'b0; en1 = 1'b0; a1 = '0; b1 = '0;
    rst4 = 1'b0; en4 = 1'b0; a4 = '0; b4 = '0;

    // Combinational truth table, one vector every 10 time units. The
    // registered path is disabled, so the clock is irrelevant here.
    for (int i = 0; i < 4; i++) begin
      a1 = tt1[i].a[0:0];
      b1 = tt1[i].b[0:0];
      #10;
      chk($sformatf("tt1_y[%0d]", i), 64'(y1), 64'(tt1[i].y[0:0]));
    end
    for (int i = 0; i < 6; i++) begin
      a4 = tt4[i].a;
      b4 = tt4[i].b;
      #10;
      chk($sformatf("tt4_y[%0d]", i), 64'(y4), 64'(tt4[i].y));
    end

    // Registered path: reset for one cycle, then a=0, b=1 with en=1.
    rst1 = 1'b1; en1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    step();
    chk("rst_yq",   64'(yq1),  64'd0);
    chk("rst_rise", 64'(yr1),  64'd0);
    chk("rst_any",  64'(any1), 64'd0);
    chk("rst_cnt",  64'(cnt1), 64'd0);
    chk("rst_sat",  64'(sat1), 64'd0);
    rst1 = 1'b0; en1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    #1;
    chk("reg_y_comb", 64'(y1), 64'd1);
    step();
    chk("reg_yq1",   64'(yq1),  64'd1);
    chk("reg_any1",  64'(any1), 64'd1);
    chk("reg_rise1", 64'(yr1),  64'd1);
    chk("reg_cnt1",  64'(cnt1), 64'd1);
    step();
    chk("reg_rise2", 64'(yr1),  64'd0);
    chk("reg_yq2",   64'(yq1),  64'd1);
    chk("reg_cnt2",  64'(cnt1), 64'd2);

    // Hold: start from y_q=0, then en=0 with a=b=1 for five cycles.
    rst1 = 1'b1; step(); rst1 = 1'b0;
    en1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    #1;
    chk("hold_y", 64'(y1), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_yq[%0d]", i),   64'(yq1),  64'd0);
      chk($sformatf("hold_any[%0d]", i),  64'(any1), 64'd0);
      chk($sformatf("hold_cnt[%0d]", i),  64'(cnt1), 64'd0);
      chk($sformatf("hold_rise[%0d]", i), 64'(yr1),  64'd0);
    end

    // Saturation with a 2-bit counter: 1,2,3,3,3,3.
    rst1 = 1'b1; step(); rst1 = 1'b0;
    en1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int exp_c;
      exp_c = (i + 1 > 3) ? 3 : i + 1;
      step();
      chk($sformatf("sat_cnt[%0d]", i), 64'(cnt1), 64'(exp_c));
      chk($sformatf("sat_flag[%0d]", i), 64'(sat1), (i >= 2) ? 64'd1 : 64'd0);
    end

    // Reset in the middle of a count.
    rst1 = 1'b1; step(); rst1 = 1'b0;
    en1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    step(); step();
    chk("mid_cnt_pre", 64'(cnt1), 64'd2);
    rst1 = 1'b1;
    step();
    chk("mid_cnt_rst",  64'(cnt1), 64'd0);
    chk("mid_yq_rst",   64'(yq1),  64'd0);
    chk("mid_rise_rst", 64'(yr1),  64'd0);
    chk("mid_sat_rst",  64'(sat1), 64'd0);
    chk("mid_y_rst",    64'(y1),   64'd1);
    rst1 = 1'b0;
    step();
    chk("mid_cnt_rel",  64'(cnt1), 64'd1);
    chk("mid_rise_rel", 64'(yr1),  64'd1);

    // WIDTH=4: first enabled edge after reset.
    rst4 = 1'b1; en4 = 1'b0; step(); rst4 = 1'b0;
    a4 = 4'b0101; b4 = 4'b0011; en4 = 1'b1;
    #1;
    chk("w4_y", 64'(y4), 64'h7);
    step();
    chk("w4_rise", 64'(yr4),  64'h7);
    chk("w4_any",  64'(any4), 64'd1);
    chk("w4_yq",   64'(yq4),  64'h7);

    // Randomized traffic on u_w4 compared against the model.
    rst4 = 1'b1; en4 = 1'b0; a4 = '0; b4 = '0;
    step();
    m_yq = 0; m_rise = 0; m_any = 0; m_cnt = 0;
    rst4 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int  ra, rb;
      bit  r_rst, r_en;
      ra    = int'($urandom_range(0, 15));
      rb    = int'($urandom_range(0, 15));
      // Bias towards sparse operands so rising edges and zero cycles occur.
      if ($urandom_range(0, 3) == 0) ra = 0;
      if ($urandom_range(0, 3) == 0) rb = 0;
      r_rst = ($urandom_range(0, 24) == 0);
      r_en  = ($urandom_range(0, 9) < 7);
      a4 = 4'(ra); b4 = 4'(rb); rst4 = r_rst; en4 = r_en;
      #1;
      chk("rnd_y", 64'(y4), 64'(ra | rb));
      step();
      model_edge(ra, rb, r_rst, r_en);
      chk("rnd_yq",   64'(yq4),  64'(m_yq));
      chk("rnd_rise", 64'(yr4),  64'(m_rise));
      chk("rnd_any",  64'(any4), 64'(m_any));
      chk("rnd_cnt",  64'(cnt4), 64'(m_cnt));
      chk("rnd_sat",  64'(sat4), (m_cnt == M_MAX) ? 64'd1 : 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
